seq_alu: RTL and testbench

- Parametrised, multi-cycle successor to the datapath ALU.
- Generalises operand width and adds the following operations:
  - SLTU, XOR, NOR
  - barrel shifts SLL, SRL, SRA
  - an iterative unsigned multiply (MUL) with full double-width product
- Uses a start/busy/done handshake so the multicycle controller can stall on long ops.
- Result, zero and overflow flags are registered and held until the next accepted operation.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/seq_mul_unit.sv | 61 ++++++
 rtl/seq_alu.sv | 129 ++++++++++++
 tb/tb_seq_alu.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared op codes and FSM state encodings for the sequential ALU.
// Codes 12-15 are deliberately left unassigned and flagged as errors.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_SLT  = 4'd4;
    localparam logic [3:0] OP_SLTU = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_NOR  = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    function automatic logic op_is_legal(input logic [3:0] op);
        return op <= OP_MUL;
    endfunction

endpackage

// File: rtl/seq_mul_unit.sv
// Radix-2 shift-add unsigned multiplier: one multiplier bit per cycle, WIDTH bits total.
// The load cycle already consumes multiplier bit 0, so the product is final after WIDTH-1 steps.
module seq_mul_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               step,
    output logic [2*WIDTH-1:0] product,
    output logic               last
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Upper half is the accumulator, lower half holds the not-yet-consumed multiplier bits.
    function automatic logic [2*WIDTH-1:0] shift_add(input logic [2*WIDTH-1:0] p,
                                                     input logic [WIDTH-1:0]   m);
        logic [WIDTH:0] sum;
        sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
        return {sum, p[WIDTH-1:1]};
    endfunction

    always_comb begin
        prod_d  = prod_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        if (load) begin
            mcand_d = a;
            prod_d  = shift_add({{WIDTH{1'b0}}, b}, a);
            cnt_d   = CNT_W'(1);
        end else if (step && !last) begin
            prod_d = shift_add(prod_q, mcand_q);
            cnt_d  = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q  <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
        end else begin
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
        end
    end

    assign product = prod_q;
    assign last    = (cnt_q == CNT_W'(WIDTH));

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus an iterative MUL.
// Handshake: start is taken only in IDLE; busy spans acceptance..done; done is a one-cycle pulse.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_hi,
    output logic             zero,
    output logic             ovf,
    output logic             err,
    output logic [1:0]       dbg_state
);

    localparam int SHAMT_W = $clog2(WIDTH);

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   y_q, y_hi_q;
    logic               zero_q, ovf_q, err_q;

    logic               accept, mul_load, wr_single, wr_mul, mul_last;
    logic [2*WIDTH-1:0] mul_product;

    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   sum, diff, res_y;
    logic               res_ovf, res_err;

    assign accept    = (state_q == S_IDLE) && start;
    assign mul_load  = accept && (op == OP_MUL);
    assign wr_single = accept && (op != OP_MUL);
    assign wr_mul    = (state_q == S_RUN) && mul_last;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = (op == OP_MUL) ? S_RUN : S_DONE;
            S_RUN:  if (mul_last) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    seq_mul_unit #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .load    (mul_load),
        .a       (a),
        .b       (b),
        .step    (state_q == S_RUN),
        .product (mul_product),
        .last    (mul_last)
    );

    assign shamt = b[SHAMT_W-1:0];
    assign sum   = a + b;
    assign diff  = a - b;

    // Operands are decoded straight off the ports on the accepting edge.
    always_comb begin
        res_y   = '0;
        res_ovf = 1'b0;
        res_err = 1'b0;
        case (op)
            OP_AND:  res_y = a & b;
            OP_OR:   res_y = a | b;
            OP_XOR:  res_y = a ^ b;
            OP_NOR:  res_y = ~(a | b);
            OP_ADD: begin
                res_y   = sum;
                res_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res_y   = diff;
                res_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT:  res_y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: res_y = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:  res_y = a << shamt;
            OP_SRL:  res_y = a >> shamt;
            OP_SRA:  res_y = $unsigned($signed(a) >>> shamt);
            default: res_err = !op_is_legal(op) || (op == OP_MUL);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            y_q     <= '0;
            y_hi_q  <= '0;
            zero_q  <= 1'b1;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (wr_single) begin
                y_q    <= res_y;
                y_hi_q <= '0;
                zero_q <= (res_y == '0);
                ovf_q  <= res_ovf;
                err_q  <= res_err;
            end else if (wr_mul) begin
                y_q    <= mul_product[WIDTH-1:0];
                y_hi_q <= mul_product[2*WIDTH-1:WIDTH];
                zero_q <= (mul_product[WIDTH-1:0] == '0);
                ovf_q  <= 1'b0;
                err_q  <= 1'b0;
            end
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign y         = y_q;
    assign y_hi      = y_hi_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed plus random checks of seq_alu at WIDTH=32 with an expected-result scoreboard.
module tb_seq_alu;
    import alu_pkg::*;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] y;
        logic [W-1:0] hi;
        logic         zero;
        logic         ovf;
        logic         err;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, zero, ovf, err;
    logic [W-1:0] y, y_hi;
    logic [1:0]   dbg_state;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .y(y), .y_hi(y_hi), .zero(zero),
        .ovf(ovf), .err(err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    // Independent reference: plain arithmetic on wide integers.
    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] z);
        exp_t          e;
        logic [63:0]   p;
        logic [4:0]    sh;
        longint        sx, sz, sr;
        e  = '0;
        sh = z[4:0];
        sx = longint'($signed(x));
        sz = longint'($signed(z));
        case (o)
            OP_AND:  e.y = x & z;
            OP_OR:   e.y = x | z;
            OP_XOR:  e.y = x ^ z;
            OP_NOR:  e.y = ~(x | z);
            OP_ADD: begin
                sr = sx + sz; e.y = sr[W-1:0];
                e.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            OP_SUB: begin
                sr = sx - sz; e.y = sr[W-1:0];
                e.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            OP_SLT:  e.y = (sx < sz) ? 32'd1 : 32'd0;
            OP_SLTU: e.y = (x < z) ? 32'd1 : 32'd0;
            OP_SLL:  e.y = x << sh;
            OP_SRL:  e.y = x >> sh;
            OP_SRA: begin
                sr = sx >>> sh; e.y = sr[W-1:0];
            end
            OP_MUL: begin
                p = 64'(x) * 64'(z); e.y = p[31:0]; e.hi = p[63:32];
            end
            default: e.err = 1'b1;
        endcase
        e.zero = (e.y == '0);
        return e;
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic do_op(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] z, input exp_t e, input int exp_lat,
                         input bit restart);
        exp_t got;
        int   lat;
        int   busy_n;
        exp_q.push_back(e);
        start = 1'b1; op = o; a = x; b = z;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        busy_n = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) busy_n++;
            if (restart && lat == 5) begin
                start = 1'b1; op = OP_ADD; a = 32'd1; b = 32'd1;
            end
            @(negedge clk);
            start = 1'b0;
            lat++;
        end
        if (busy === 1'b1) busy_n++;
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_lat));
        if (exp_q.size() > 0) begin
            got = exp_q.pop_front();
            check({tag, "_y"}, 64'(y), 64'(got.y));
            check({tag, "_y_hi"}, 64'(y_hi), 64'(got.hi));
            check({tag, "_flags"}, 64'({zero, ovf, err}), 64'({got.zero, got.ovf, got.err}));
        end
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'({done, dbg_state}), 64'({1'b0, S_IDLE}));
        check({tag, "_hold_y"}, 64'(y), 64'(got.y));
    endtask

    function automatic exp_t mk(input logic [W-1:0] yy, input logic [W-1:0] hh,
                                input logic zz, input logic oo, input logic ee);
        exp_t e;
        e.y = yy; e.hi = hh; e.zero = zz; e.ovf = oo; e.err = ee;
        return e;
    endfunction

    initial begin
        int dn;
        logic [3:0]   ro;
        logic [W-1:0] ra, rb;

        // Reset
        repeat (2) @(negedge clk);
        check("reset_y", 64'({y, y_hi}), 64'd0);
        check("reset_flags", 64'({zero, ovf, err, busy, done}), 64'b10000);
        check("reset_state", 64'(dbg_state), 64'(S_IDLE));
        rst = 1'b0;
        @(negedge clk);

        do_op("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'd1, mk(32'h8000_0000, 0, 0, 1, 0), 1, 0);
        do_op("sub_zero", OP_SUB, 32'd41, 32'd41, mk(32'd0, 0, 1, 0, 0), 1, 0);
        do_op("slt_0", OP_SLT, 32'hFFFF_FFFD, 32'hFFFF_FFFB, mk(32'd0, 0, 1, 0, 0), 1, 0);
        do_op("slt_1", OP_SLT, 32'hFFFF_FFFB, 32'hFFFF_FFFD, mk(32'd1, 0, 0, 0, 0), 1, 0);
        do_op("sltu", OP_SLTU, 32'd41, 32'hFFFF_FFFF, mk(32'd1, 0, 0, 0, 0), 1, 0);
        do_op("sra", OP_SRA, 32'h8000_0010, 32'h24, mk(32'hF800_0001, 0, 0, 0, 0), 1, 0);
        do_op("srl", OP_SRL, 32'h8000_0010, 32'h24, mk(32'h0800_0001, 0, 0, 0, 0), 1, 0);
        do_op("sll", OP_SLL, 32'd1, 32'd31, mk(32'h8000_0000, 0, 0, 0, 0), 1, 0);
        do_op("sub_ovf", OP_SUB, 32'h8000_0000, 32'd1, mk(32'h7FFF_FFFF, 0, 0, 1, 0), 1, 0);
        do_op("nor", OP_NOR, 32'h0F0F_0000, 32'h0000_00FF, mk(32'hF0F0_FF00, 0, 0, 0, 0), 1, 0);
        do_op("mul_max", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              mk(32'h0000_0001, 32'hFFFF_FFFE, 0, 0, 0), W + 1, 0);
        do_op("mul_small", OP_MUL, 32'd41, 32'd8, mk(32'd328, 0, 0, 0, 0), W + 1, 1);

        // Reset ten cycles into a multiply
        start = 1'b1; op = OP_MUL; a = 32'd5; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_state", 64'(dbg_state), 64'(S_IDLE));
        check("rst_mid_out", 64'({y, zero, busy}), 64'({32'd0, 1'b1, 1'b0}));
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
        end
        check("rst_mid_no_done", 64'(dn), 64'd0);
        do_op("add_after_rst", OP_ADD, 32'd2, 32'd3, mk(32'd5, 0, 0, 0, 0), 1, 0);

        do_op("illegal", 4'd13, 32'h1234, 32'h5678, mk(32'd0, 0, 1, 0, 1), 1, 0);
        do_op("err_clear", OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, mk(32'h0F00_0F00, 0, 0, 0, 0), 1, 0);

        // Random single-cycle ops and one random multiply against the reference
        for (int i = 0; i < 8; i++) begin
            ro = 4'($urandom_range(0, 10));
            ra = $urandom;
            rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(0, 70));
            do_op("rand", ro, ra, rb, model(ro, ra, rb), 1, 0);
        end
        ra = $urandom;
        rb = $urandom;
        do_op("rand_mul", OP_MUL, ra, rb, model(OP_MUL, ra, rb), W + 1, 0);
        ro = 4'($urandom_range(12, 15));
        do_op("rand_illegal", ro, ra, rb, model(ro, ra, rb), 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
